arf104b256e1r1w0cbbehcaa4acw_wr_front: RTL and testbench

- Write-port front end for the 104b x 256-entry 1R1W array.
- Accepts write requests over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the array write port and the write clock-gate enable (arr_wclk_en feeds the array's clk_and gate).
- Clears all entries to INIT_VAL after reset and on request; holds off traffic while the array signals a stall.

---
 rtl/arf104b256e1r1w0cbbehcaa4acw_wr_pkg.sv | 14 +
 rtl/arf104b256e1r1w0cbbehcaa4acw_wr_fifo2.sv | 39 +++
 rtl/arf104b256e1r1w0cbbehcaa4acw_wr_front.sv | 129 ++++++++++++
 tb/tb_arf104b256e1r1w0cbbehcaa4acw_wr_front.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_wr_pkg.sv
// Shared types and constants for the 104b x 256 1R1W array write front end.
package arf104b256e1r1w0cbbehcaa4acw_wr_pkg;
  localparam int DATA_W = 104;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] INIT_VAL = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} wr_state_e;
endpackage

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_wr_fifo2.sv
// Two-entry write-request FIFO; a push into a full FIFO is legal only with a same-cycle pop.
module arf104b256e1r1w0cbbehcaa4acw_wr_fifo2
  import arf104b256e1r1w0cbbehcaa4acw_wr_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  logic    i_pop,
  input  wr_req_t i_data,
  output wr_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);
  wr_req_t    r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
endmodule

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_wr_front.sv
// Write-port front end: init sequencer, request FIFO and array write mux.
// ARF104B256E1R1W0CBBEHCAA4ACW_WR_INFLOP_EN adds a register stage between the handshake and the FIFO.
module arf104b256e1r1w0cbbehcaa4acw_wr_front
  import arf104b256e1r1w0cbbehcaa4acw_wr_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic              i_init_req,
  input  logic              i_arr_stall,
  output logic              o_arr_wr_en,
  output logic [ADDR_W-1:0] o_arr_wr_addr,
  output logic [DATA_W-1:0] o_arr_wr_data,
  output logic              o_arr_wclk_en,
  output logic              o_init_busy,
  output logic              o_init_done
);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  wr_state_e         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_live;
  logic              r_ready;

  wr_req_t    w_in_req;
  wr_req_t    w_push_req;
  wr_req_t    w_head;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_init_wr;
  logic       w_pipe_empty;
  logic [1:0] w_occ;
  logic [1:0] w_occ_next;

  // Handshake: a request transfers on a cycle where i_req_valid and o_req_ready are both high;
  // o_req_ready is a register, so it never depends on i_req_valid or i_arr_stall in that cycle.
  assign w_in_req.addr = i_req_addr;
  assign w_in_req.data = i_req_data;
  assign w_accept      = i_req_valid && r_ready;
  assign w_occ         = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_WR_INFLOP_EN
  logic    r_stg_vld;
  wr_req_t r_stg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stg_vld <= 1'b0;
      r_stg     <= '0;
    end else begin
      r_stg_vld <= w_accept;
      if (w_accept) r_stg <= w_in_req;
    end
  end

  assign w_push       = r_stg_vld;
  assign w_push_req   = r_stg;
  assign w_occ_next   = w_occ + {1'b0, w_push} - {1'b0, w_pop} + {1'b0, w_accept};
  assign w_pipe_empty = w_empty && !r_stg_vld;
`else
  assign w_push       = w_accept;
  assign w_push_req   = w_in_req;
  assign w_occ_next   = w_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_pipe_empty = w_empty;
`endif

  arf104b256e1r1w0cbbehcaa4acw_wr_fifo2 u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_req),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // r_live keeps the write strobe quiet until the first clock edge after reset.
  assign w_init_wr = (r_state == S_INIT) && r_live && !i_arr_stall;
  assign w_pop     = (r_state != S_INIT) && !w_empty && !i_arr_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_live  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_ready <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (w_init_wr) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_init_req) r_state <= S_DRAIN;
          else            r_ready <= (w_occ_next < 2'd2);
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign o_req_ready   = r_ready;
  assign o_arr_wr_en   = w_init_wr || w_pop;
  assign o_arr_wclk_en = o_arr_wr_en;
  assign o_arr_wr_addr = (r_state == S_INIT) ? r_cnt : w_head.addr;
  assign o_arr_wr_data = (r_state == S_INIT) ? INIT_VAL : w_head.data;
  assign o_init_busy   = (r_state == S_INIT);
  assign o_init_done   = (r_state == S_RUN);
endmodule

// File: tb/tb_arf104b256e1r1w0cbbehcaa4acw_wr_front.sv
// Scoreboard bench for the array write front end: init sweeps, stalls, FIFO traffic, re-init and reset abort.
`timescale 1ns/1ps
module tb_arf104b256e1r1w0cbbehcaa4acw_wr_front;
  import arf104b256e1r1w0cbbehcaa4acw_wr_pkg::*;
  localparam int EW = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              init_req = 1'b0;
  logic              arr_stall = 1'b0;
  logic              arr_wr_en;
  logic [ADDR_W-1:0] arr_wr_addr;
  logic [DATA_W-1:0] arr_wr_data;
  logic              arr_wclk_en;
  logic              init_busy;
  logic              init_done;

  logic [EW-1:0] exp_q[$];
  int            wr_cyc[$];
  int            acc_cyc[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arf104b256e1r1w0cbbehcaa4acw_wr_front dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .i_init_req    (init_req),
    .i_arr_stall   (arr_stall),
    .o_arr_wr_en   (arr_wr_en),
    .o_arr_wr_addr (arr_wr_addr),
    .o_arr_wr_data (arr_wr_data),
    .o_arr_wclk_en (arr_wclk_en),
    .o_init_busy   (init_busy),
    .o_init_done   (init_done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && (arr_wr_en || arr_wclk_en)) begin
      check("wclk_en equals wr_en", 128'(arr_wclk_en), 128'(arr_wr_en));
      if (arr_wr_en) begin
        check("no write under stall", 128'(arr_stall), 128'(0));
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected write: got addr %0h data %0h, required none", arr_wr_addr, arr_wr_data);
        end else begin
          check("array write {addr,data}", 128'({arr_wr_addr, arr_wr_data}), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_init();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), INIT_VAL});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"}, 128'(req_ready), 128'(0));
    check({tag, " arr_wr_en"}, 128'(arr_wr_en), 128'(0));
    check({tag, " arr_wclk_en"}, 128'(arr_wclk_en), 128'(0));
    check({tag, " arr_wr_addr"}, 128'(arr_wr_addr), 128'(0));
    check({tag, " arr_wr_data"}, 128'(arr_wr_data), 128'(0));
    check({tag, " init_busy"}, 128'(init_busy), 128'(1));
    check({tag, " init_done"}, 128'(init_done), 128'(0));
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int k;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready) break;
      @(posedge clk); #1;
    end
    if (k == 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL send timeout: request %0h not accepted in 60 cycles, required acceptance", a);
    end else begin
      exp_q.push_back({a, d});
      acc_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
  endtask

  // Watches one init sweep; optionally stalls 3 cycles at stall_at and pulses init_req at pulse_at.
  task automatic run_init(input string tag, input int stall_at, input int pulse_at, input int exp_span);
    int   first = -1, last = -1, n = 0, done_cyc = -1, rdy_bad = 0, held_bad = 0, stall_left = 0;
    logic want_stall, want_pulse;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (init_done) begin
        done_cyc = cyc;
        break;
      end
      if (req_ready) rdy_bad++;
      if (arr_stall && (int'(arr_wr_addr) != stall_at || arr_wr_en)) held_bad++;
      if (init_busy && arr_wr_en) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
      want_stall = 1'b0;
      want_pulse = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        want_stall = (stall_left > 0);
      end
      if (init_busy && arr_wr_en && int'(arr_wr_addr) == stall_at - 1) begin
        stall_left = 3;
        want_stall = 1'b1;
      end
      if (init_busy && arr_wr_en && int'(arr_wr_addr) == pulse_at - 1) want_pulse = 1'b1;
      if (want_stall !== arr_stall || want_pulse !== init_req) begin
        @(posedge clk); #1;
        arr_stall = want_stall;
        init_req  = want_pulse;
      end
    end
    check({tag, " init_done reached"}, 128'(done_cyc >= 0), 128'(1));
    check({tag, " init write count"}, 128'(n), 128'(DEPTH));
    check({tag, " init span cycles"}, 128'(last - first + 1), 128'(exp_span));
    check({tag, " init_done follows last write"}, 128'(done_cyc), 128'(last + 1));
    check({tag, " req_ready low before done"}, 128'(rdy_bad), 128'(0));
    check({tag, " stall holds address"}, 128'(held_bad), 128'(0));
    check({tag, " req_ready after done"}, 128'(req_ready), 128'(1));
    check({tag, " init_busy after done"}, 128'(init_busy), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    logic [ADDR_W-1:0] c_addr [8];
    logic [DATA_W-1:0] c_data [8];
    c_addr = '{8'h10, 8'h11, 8'h10, 8'h12, 8'h13, 8'h10, 8'hFF, 8'h00};
    c_data = '{104'h1, 104'h2, 104'h3, 104'hDEAD, 104'hBEEF, 104'h4,
               {104{1'b1}}, 104'hF0F0_0000_0000_0000_0000_0F0F};

    #1 rst = 1'b1;
    #2 check_reset_vals("reset");
    repeat (3) tick();
    rst = 1'b0;
    push_init();
    run_init("init0", -1, -1, 256);

    // Stalled array: two requests fill the FIFO, the third waits.
    arr_stall = 1'b1;
    wr_cyc.delete();
    n0 = acc_cyc.size();
    fork
      begin
        send(8'h05, 104'hA);
        send(8'h06, 104'hB);
        send(8'h07, 104'hC);
        req_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall two accepted", 128'(acc_cyc.size() - n0), 128'(2));
        check("stall ready low when full", 128'(req_ready), 128'(0));
        check("stall nothing written", 128'(wr_cyc.size()), 128'(0));
        arr_stall = 1'b0;
      end
    join
    repeat (3) tick();
    check("stall release write count", 128'(wr_cyc.size()), 128'(3));
    if (wr_cyc.size() == 3) begin
      check("stall release 2nd consecutive", 128'(wr_cyc[1]), 128'(wr_cyc[0] + 1));
      check("stall release 3rd consecutive", 128'(wr_cyc[2]), 128'(wr_cyc[0] + 2));
    end

    // Continuous traffic: one accept per cycle, one-cycle latency, same-address order kept.
    wr_cyc.delete();
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) send(c_addr[i], c_data[i]);
    req_valid = 1'b0;
    repeat (3) tick();
    check("stream accept count", 128'(acc_cyc.size()), 128'(8));
    check("stream write count", 128'(wr_cyc.size()), 128'(8));
    if (acc_cyc.size() == 8 && wr_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("stream back-to-back accept", 128'(acc_cyc[i]), 128'(acc_cyc[0] + i));
        check("stream one-cycle latency", 128'(wr_cyc[i]), 128'(acc_cyc[i] + 1));
      end
    end

    // init_req with two queued entries, the second accepted in the init_req cycle.
    arr_stall = 1'b1;
    send(8'h20, 104'h111);
    init_req = 1'b1;
    send(8'h21, 104'h222);
    init_req  = 1'b0;
    req_valid = 1'b0;
    repeat (2) tick();
    check("drain ready low", 128'(req_ready), 128'(0));
    check("drain init_done low", 128'(init_done), 128'(0));
    check("drain init_busy low", 128'(init_busy), 128'(0));
    arr_stall = 1'b0;
    push_init();
    run_init("reinit", -1, 200, 256);

    // Reset mid-init at address 37, then a sweep with a 3-cycle stall at address 100.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    push_init();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (arr_wr_en && arr_wr_addr == 8'd36) break;
    end
    @(posedge clk); #1;
    check("abort at address 37", 128'(arr_wr_addr), 128'(37));
    rst = 1'b1;
    #1 check_reset_vals("async reset");
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    push_init();
    run_init("restart", 100, -1, 259);

    repeat (3) tick();
    check("scoreboard drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
